// File: rtl/rwc_pkg.sv
// Shared types and helpers for the read-write-collision PUF generator.
// Holds the FSM state encoding, the default clear pattern, the parameter bounds and a clog2 helper.
package rwc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        RD_DATA,
        WR_CLR,
        RD_CLR,
        VOTE,
        HOLD
    } rwc_state_e;

    // The clear phase writes this bit replicated across the full data width.
    localparam logic CLEAR_BIT_DEFAULT = 1'b0;

    localparam int N_EVAL_MIN = 1;
    localparam int N_EVAL_MAX = 255;
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    function automatic int rwc_clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rwc_we_pulse.sv
// Dual-edge toggle pulse generator: one fire cycle yields a write enable that is high
// from the posedge to the following negedge. This is the only negedge logic in the block.
module rwc_we_pulse (
    input  logic clk,
    input  logic w_resetn,
    input  logic fire,
    output logic we
);

    logic we_pos_q;
    logic we_pos_d;
    logic we_neg_q;

    always_comb begin
        we_pos_d = fire ? ~we_pos_q : we_pos_q;
    end

    // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!w_resetn) begin
            we_pos_q <= 1'b0;
        end else begin
            we_pos_q <= we_pos_d;
        end
    end

    // NOTE: the falling-edge copy takes its reset through we_pos; a local reset here could
    // clear it while we_pos is still 1 and open a spurious write pulse.
    always_ff @(negedge clk) begin
        we_neg_q <= we_pos_q;
    end

    assign we = we_pos_q ^ we_neg_q;

endmodule

// File: rtl/rwc_puf_gen.sv
// Read-write-collision PUF generator: runs N_EVAL data/clear collision evaluations per
// challenge and returns per-bit majority votes plus a unanimity (stability) mask.
module rwc_puf_gen
    import rwc_pkg::*;
#(
    parameter int              DW            = 32,
    parameter int              AW            = 10,
    parameter int              N_EVAL        = 8,
    parameter int              RD_LAT        = 1,
    parameter logic [DW-1:0]   CLEAR_PATTERN = {DW{CLEAR_BIT_DEFAULT}}
) (
    input  logic          clk,
    input  logic          w_resetn,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [DW-1:0] req_data,
    input  logic [AW-1:0] req_addr,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_write,
    output logic [DW-1:0] rsp_clean,
    output logic [DW-1:0] rsp_stable,
    output logic          bram_we,
    output logic [AW-1:0] bram_addr,
    output logic [DW-1:0] bram_din,
    input  logic [DW-1:0] bram_dout
);

    localparam int TW  = rwc_clog2(N_EVAL + 1);
    localparam int TW1 = TW + 1;
    localparam int RW  = rwc_clog2(RD_LAT + 1);

    localparam logic [TW-1:0]  N_FULL  = TW'(N_EVAL);
    localparam logic [TW1-1:0] N_VOTE  = TW1'(N_EVAL);
    localparam logic [RW-1:0]  RD_LAST = RW'(RD_LAT - 1);

    rwc_state_e    state_q, state_d;
    logic          req_ready_q, req_ready_d;
    logic [DW-1:0] data_q, data_d;
    logic [DW-1:0] din_q, din_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [RW-1:0] rd_cnt_q, rd_cnt_d;
    logic [TW-1:0] eval_cnt_q, eval_cnt_d;
    logic [DW-1:0] rsp_write_q, rsp_write_d;
    logic [DW-1:0] rsp_clean_q, rsp_clean_d;
    logic [DW-1:0] rsp_stable_q, rsp_stable_d;

    logic          accept;
    logic          rd_last;
    logic          tally_clr;
    logic          tally_w_en;
    logic          tally_c_en;
    logic          vote_en;
    logic          fire;
    logic [DW-1:0] vote_w;
    logic [DW-1:0] vote_c;
    logic [DW-1:0] vote_s;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        addr_d       = addr_q;
        din_d        = din_q;
        rd_cnt_d     = rd_cnt_q;
        eval_cnt_d   = eval_cnt_q;
        tally_clr    = 1'b0;
        tally_w_en   = 1'b0;
        tally_c_en   = 1'b0;
        vote_en      = 1'b0;
        accept       = req_valid && req_ready_q;
        rd_last      = (rd_cnt_q == RD_LAST);

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d     = req_data;
                    addr_d     = req_addr;
                    eval_cnt_d = '0;
                    tally_clr  = 1'b1;
                    state_d    = WR_DATA;
                end
            end
            WR_DATA: begin
                rd_cnt_d = '0;
                state_d  = RD_DATA;
            end
            RD_DATA: begin
                if (rd_last) begin
                    tally_w_en = 1'b1;
                    state_d    = WR_CLR;
                end else begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
            end
            WR_CLR: begin
                rd_cnt_d = '0;
                state_d  = RD_CLR;
            end
            RD_CLR: begin
                if (rd_last) begin
                    tally_c_en = 1'b1;
                    eval_cnt_d = eval_cnt_q + 1'b1;
                    state_d    = (eval_cnt_d == N_FULL) ? VOTE : WR_DATA;
                end else begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
            end
            VOTE: begin
                vote_en = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The write pulse and its data both launch at the edge that enters a write state.
        fire = (state_d == WR_DATA) || (state_d == WR_CLR);
        if (state_d == WR_DATA) begin
            din_d = data_d;
        end else if (state_d == WR_CLR) begin
            din_d = CLEAR_PATTERN;
        end

        req_ready_d  = (state_d == IDLE);
        rsp_write_d  = vote_en ? vote_w : rsp_write_q;
        rsp_clean_d  = vote_en ? vote_c : rsp_clean_q;
        rsp_stable_d = vote_en ? vote_s : rsp_stable_q;
    end

    always_ff @(posedge clk) begin
        if (!w_resetn) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b0;
            data_q       <= '0;
            addr_q       <= '0;
            din_q        <= '0;
            rd_cnt_q     <= '0;
            eval_cnt_q   <= '0;
            rsp_write_q  <= '0;
            rsp_clean_q  <= '0;
            rsp_stable_q <= '0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            data_q       <= data_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
            rd_cnt_q     <= rd_cnt_d;
            eval_cnt_q   <= eval_cnt_d;
            rsp_write_q  <= rsp_write_d;
            rsp_clean_q  <= rsp_clean_d;
            rsp_stable_q <= rsp_stable_d;
        end
    end

    // Per-bit tally and vote; 2*tally is formed by a left shift at TW+1 bits.
    for (genvar i = 0; i < DW; i++) begin : g_bit
        logic [TW-1:0] tally_w_q, tally_w_d;
        logic [TW-1:0] tally_c_q, tally_c_d;

        always_comb begin
            tally_w_d = tally_w_q;
            tally_c_d = tally_c_q;
            if (tally_clr) begin
                tally_w_d = '0;
                tally_c_d = '0;
            end else begin
                if (tally_w_en) tally_w_d = tally_w_q + TW'(bram_dout[i]);
                if (tally_c_en) tally_c_d = tally_c_q + TW'(bram_dout[i]);
            end
        end

        always_ff @(posedge clk) begin
            if (!w_resetn) begin
                tally_w_q <= '0;
                tally_c_q <= '0;
            end else begin
                tally_w_q <= tally_w_d;
                tally_c_q <= tally_c_d;
            end
        end

        assign vote_w[i] = ({tally_w_q, 1'b0} > N_VOTE);
        assign vote_c[i] = ({tally_c_q, 1'b0} > N_VOTE);
        assign vote_s[i] = ((tally_w_q == '0) || (tally_w_q == N_FULL)) &&
                           ((tally_c_q == '0) || (tally_c_q == N_FULL));
    end

    rwc_we_pulse u_we_pulse (
        .clk      (clk),
        .w_resetn (w_resetn),
        .fire     (fire),
        .we       (bram_we)
    );

    assign req_ready  = req_ready_q;
    assign rsp_valid  = (state_q == HOLD);
    assign rsp_write  = rsp_write_q;
    assign rsp_clean  = rsp_clean_q;
    assign rsp_stable = rsp_stable_q;
    assign bram_addr  = addr_q;
    assign bram_din   = din_q;

endmodule

// File: tb/tb_rwc_puf_gen.sv
// Self-checking bench for rwc_puf_gen: table vectors, stall/reset sequences, randomized
// challenges against a tally-and-vote reference model, and a small-parameter instance.
`timescale 1ns/1ps
module tb_rwc_puf_gen;

    localparam int DW   = 32;
    localparam int AW   = 10;
    localparam int N    = 8;
    localparam int LAT  = 2 * N * (1 + 1) + 1;
    localparam int HALF = 5;

    logic clk = 1'b0;
    always #HALF clk = ~clk;

    logic          w_resetn;
    logic          req_valid, req_ready, rsp_valid, rsp_ready, bram_we;
    logic [DW-1:0] req_data, rsp_write, rsp_clean, rsp_stable, bram_din, bram_dout;
    logic [AW-1:0] req_addr, bram_addr;

    rwc_puf_gen #(.DW(DW), .AW(AW), .N_EVAL(N), .RD_LAT(1)) dut (
        .clk(clk), .w_resetn(w_resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_write(rsp_write), .rsp_clean(rsp_clean), .rsp_stable(rsp_stable),
        .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din), .bram_dout(bram_dout)
    );

    logic       req_valid2, req_ready2, rsp_valid2, rsp_ready2, bram_we2;
    logic [7:0] req_data2, rsp_write2, rsp_clean2, rsp_stable2, bram_din2, bram_dout2;
    logic [3:0] req_addr2, bram_addr2;

    rwc_puf_gen #(.DW(8), .AW(4), .N_EVAL(1), .RD_LAT(2)) dut_small (
        .clk(clk), .w_resetn(w_resetn),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_data(req_data2), .req_addr(req_addr2),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2),
        .rsp_write(rsp_write2), .rsp_clean(rsp_clean2), .rsp_stable(rsp_stable2),
        .bram_we(bram_we2), .bram_addr(bram_addr2), .bram_din(bram_din2), .bram_dout(bram_dout2)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // BRAM model: read data is the last written word, optionally disturbed per write.
    logic [DW-1:0] mem_q;
    logic [DW-1:0] flips [2*N];
    int            wcnt, pulses, bad_width;
    realtime       t_rise;

    always @(posedge bram_we) t_rise = $realtime;
    always @(negedge bram_we) begin
        mem_q = bram_din;
        wcnt++;
        pulses++;
        if ($realtime - t_rise != HALF) bad_width++;
    end

    always_comb begin
        bram_dout = mem_q;
        if (wcnt >= 1 && wcnt <= 2 * N) bram_dout = mem_q ^ flips[wcnt-1];
    end

    logic [7:0] mem2_q;
    int         pulses2;
    always @(negedge bram_we2) begin
        mem2_q = bram_din2;
        pulses2++;
    end
    assign bram_dout2 = mem2_q;

    // Reference: count observed ones per bit across evaluations, vote and test unanimity.
    function automatic void model(input logic [DW-1:0] data, output logic [DW-1:0] ew,
                                  output logic [DW-1:0] ec, output logic [DW-1:0] es);
        int cw, cc;
        for (int i = 0; i < DW; i++) begin
            cw = 0;
            cc = 0;
            for (int e = 0; e < N; e++) begin
                cw += int'(data[i] ^ flips[2*e][i]);
                cc += int'(flips[2*e+1][i]);
            end
            ew[i] = (2 * cw > N);
            ec[i] = (2 * cc > N);
            es[i] = (cw == 0 || cw == N) && (cc == 0 || cc == N);
        end
    endfunction

    task automatic set_flips(input int fbit, input int nw, input int nc);
        for (int e = 0; e < N; e++) begin
            flips[2*e]   = (e < nw) ? (32'd1 << fbit) : '0;
            flips[2*e+1] = (e < nc) ? (32'd1 << fbit) : '0;
        end
    endtask

    task automatic start_req(input logic [DW-1:0] data, input logic [AW-1:0] addr);
        check("req_ready_before_accept", req_ready, 1'b1);
        wcnt = 0;
        pulses = 0;
        bad_width = 0;
        req_valid = 1'b1;
        req_data  = data;
        req_addr  = addr;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_data  = $urandom;
        req_addr  = AW'($urandom);
    endtask

    task automatic wait_rsp(output int lat);
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if (rsp_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic release_rsp(input int stall);
        logic [DW-1:0] snap;
        snap = rsp_write;
        repeat (stall) begin @(posedge clk); #1; end
        check("rsp_held_valid", rsp_valid, 1'b1);
        check("rsp_held_write", rsp_write, snap);
        rsp_ready = 1'b1;
        check("req_ready_in_hs_cycle", req_ready, 1'b0);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("req_ready_after_hs", req_ready, 1'b1);
        check("rsp_valid_after_hs", rsp_valid, 1'b0);
    endtask

    task automatic run_and_check(input string tag, input logic [DW-1:0] data, input logic [AW-1:0] addr,
                                 input int stall, input logic [DW-1:0] ew, input logic [DW-1:0] ec,
                                 input logic [DW-1:0] es);
        int lat;
        start_req(data, addr);
        wait_rsp(lat);
        check({tag, "_latency"}, lat, LAT);
        check({tag, "_write"}, rsp_write, ew);
        check({tag, "_clean"}, rsp_clean, ec);
        check({tag, "_stable"}, rsp_stable, es);
        check({tag, "_pulses"}, pulses, 2 * N);
        check({tag, "_pulse_width"}, bad_width, 0);
        check({tag, "_addr"}, bram_addr, addr);
        release_rsp(stall);
    endtask

    typedef struct packed {
        logic [31:0] data;
        logic [9:0]  addr;
        logic [7:0]  fbit;
        logic [7:0]  nw;
        logic [7:0]  nc;
        logic [31:0] ew;
        logic [31:0] ec;
        logic [31:0] es;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int            lat, bad, p0;
        logic [DW-1:0] ew, ec, es, w0;
        logic [DW-1:0] rdata;

        vecs[0] = '{32'hA5A5_0F0F, 10'h3FF, 8'd0,  8'd0, 8'd0, 32'hA5A5_0F0F, 32'h0000_0000, 32'hFFFF_FFFF};
        vecs[1] = '{32'hA5A5_0F0F, 10'h001, 8'd0,  8'd3, 8'd0, 32'hA5A5_0F0F, 32'h0000_0000, 32'hFFFF_FFFE};
        vecs[2] = '{32'hA5A5_0F0F, 10'h002, 8'd0,  8'd4, 8'd0, 32'hA5A5_0F0E, 32'h0000_0000, 32'hFFFF_FFFE};
        vecs[3] = '{32'h1234_5678, 10'h200, 8'd31, 8'd0, 8'd5, 32'h1234_5678, 32'h8000_0000, 32'h7FFF_FFFF};
        vecs[4] = '{32'hDEAD_BEEF, 10'h000, 8'd4,  8'd8, 8'd0, 32'hDEAD_BEFF, 32'h0000_0000, 32'hFFFF_FFFF};

        w_resetn = 1'b0;
        req_valid = 1'b0; rsp_ready = 1'b0; req_data = '0; req_addr = '0;
        req_valid2 = 1'b0; rsp_ready2 = 1'b0; req_data2 = '0; req_addr2 = '0;
        set_flips(0, 0, 0);
        wcnt = 0; pulses = 0; bad_width = 0; pulses2 = 0;
        repeat (3) begin @(posedge clk); #1; end
        check("reset_req_ready_low", req_ready, 1'b0);
        w_resetn = 1'b1;
        @(posedge clk); #1;
        check("reset_req_ready", req_ready, 1'b1);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_bram_we", bram_we, 1'b0);
        check("reset_rsp_write", rsp_write, '0);
        check("reset_rsp_clean", rsp_clean, '0);
        check("reset_rsp_stable", rsp_stable, '0);
        check("reset_bram_addr", bram_addr, '0);
        check("reset_bram_din", bram_din, '0);

        for (int v = 0; v < 5; v++) begin
            set_flips(int'(vecs[v].fbit), int'(vecs[v].nw), int'(vecs[v].nc));
            run_and_check($sformatf("vec%0d", v), vecs[v].data, vecs[v].addr, v % 3,
                          vecs[v].ew, vecs[v].ec, vecs[v].es);
        end

        // Response stall with a competing request pending, then back-to-back acceptance.
        set_flips(0, 0, 0);
        start_req(32'h0F1E_2D3C, 10'h055);
        wait_rsp(lat);
        check("stall_latency", lat, LAT);
        w0 = rsp_write;
        check("stall_first_write", w0, 32'h0F1E_2D3C);
        req_valid = 1'b1; req_data = 32'hC3C3_5A5A; req_addr = 10'h2AA;
        p0 = pulses;
        bad = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_write !== w0 || bram_we !== 1'b0) bad++;
        end
        check("stall_outputs_stable", bad, 0);
        check("stall_no_pulses", pulses, p0);
        check("stall_addr_kept", bram_addr, 10'h055);
        release_rsp(0);
        run_and_check("second", 32'hC3C3_5A5A, 10'h2AA, 0, 32'hC3C3_5A5A, '0, '1);

        // Reset during RD_CLR of the fifth evaluation (entered at the 19th edge after accept).
        start_req(32'h1357_9BDF, 10'h100);
        repeat (19) @(posedge clk);
        #1;
        w_resetn = 1'b0;
        @(posedge clk);
        @(negedge clk); #1;
        check("midrst_we_low", bram_we, 1'b0);
        check("midrst_req_ready_low", req_ready, 1'b0);
        check("midrst_rsp_valid", rsp_valid, 1'b0);
        w_resetn = 1'b1;
        @(posedge clk); #1;
        check("midrst_idle", req_ready, 1'b1);
        bad = 0;
        repeat (40) begin @(posedge clk); #1; if (rsp_valid !== 1'b0) bad++; end
        check("midrst_no_rsp", bad, 0);
        run_and_check("post_reset", 32'h1357_9BDF, 10'h100, 1, 32'h1357_9BDF, '0, '1);

        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 2 * N; k++) flips[k] = $urandom & $urandom & $urandom;
            rdata = $urandom;
            model(rdata, ew, ec, es);
            run_and_check($sformatf("rand%0d", r), rdata, AW'($urandom), int'($urandom_range(0, 3)), ew, ec, es);
        end

        // Small instance: N_EVAL=1, RD_LAT=2.
        check("small_req_ready", req_ready2, 1'b1);
        pulses2 = 0;
        req_valid2 = 1'b1; req_data2 = 8'h6C; req_addr2 = 4'h9;
        @(posedge clk); #1;
        req_valid2 = 1'b0; req_data2 = 8'h00;
        lat = -1;
        for (int k = 1; k <= 50; k++) begin
            @(posedge clk); #1;
            if (rsp_valid2 === 1'b1) begin lat = k; break; end
        end
        check("small_latency", lat, 7);
        check("small_write", rsp_write2, 8'h6C);
        check("small_clean", rsp_clean2, 8'h00);
        check("small_stable", rsp_stable2, 8'hFF);
        check("small_pulses", pulses2, 2);
        check("small_addr", bram_addr2, 4'h9);
        rsp_ready2 = 1'b1;
        @(posedge clk); #1;
        rsp_ready2 = 1'b0;
        check("small_idle", req_ready2, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rwc_puf_gen.md
# rwc_puf_gen

Parametrised read-write-collision PUF generator, successor to the single-shot 32-bit controller. It accepts a challenge (data, address) over a valid/ready handshake and drives an external single-port BRAM with half-cycle collision write pulses. It repeats the write/clear evaluation N_EVAL times and majority-votes each bit. It returns the voted write response, the voted clear response and a per-bit stability mask to the PUF top level over a valid/ready handshake.

## Interface
- DW, 32, challenge/response data width
- AW, 10, BRAM address width
- N_EVAL, 8, evaluations per challenge (1..255)
- RD_LAT, 1, BRAM read latency in cycles (1..4)
- CLEAR_PATTERN, {DW{1'b0}}, data written in the clear phase
- clk  in  1  clock; all logic posedge except the we-pulse falling toggle (negedge)
- w_resetn  in  1  reset, synchronous, active-low
- req_valid  in  1  challenge present
- req_ready  out  1  block idle, can accept
- req_data  in  DW  challenge data
- req_addr  in  AW  challenge address
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_write  out  DW  voted response after challenge-data collision
- rsp_clean  out  DW  voted response after clear-pattern collision
- rsp_stable  out  DW  1 = bit unanimous across all evaluations in both phases
- bram_we  out  1  collision write pulse
- bram_addr  out  AW  latched req_addr
- bram_din  out  DW  req_data or CLEAR_PATTERN
- bram_dout  in  DW  BRAM read data

## Operation
- States: IDLE, WR_DATA, RD_DATA, WR_CLR, RD_CLR, VOTE, HOLD.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch req_data and req_addr, clear all tally counters and eval_cnt, go to WR_DATA.
- WR_DATA (1 cycle):
  - bram_din=latched data; issue one we pulse.
  - Next state RD_DATA.
- RD_DATA (RD_LAT cycles):
  - On the last cycle, for each bit i: tally_w[i] += bram_dout[i].
  - Next state WR_CLR.
- WR_CLR (1 cycle) then RD_CLR (RD_LAT cycles):
  - Same as WR_DATA/RD_DATA, with bram_din=CLEAR_PATTERN and tallies going to tally_c.
  - At the end of RD_CLR, eval_cnt++. If eval_cnt==N_EVAL go to VOTE, else go to WR_DATA.
- VOTE (1 cycle), per bit:
  - rsp_write[i] = (2*tally_w[i] > N_EVAL); ties resolve to 0.
  - rsp_clean[i] is computed the same way from tally_c.
  - rsp_stable[i] = (tally_w[i] ∈ {0,N_EVAL}) && (tally_c[i] ∈ {0,N_EVAL}).
  - Go to HOLD.
- HOLD:
  - rsp_valid=1; outputs stay stable until rsp_valid&&rsp_ready, then go to IDLE.
  - req_ready is 0 in HOLD. It is not re-asserted in the handshake cycle; it rises on the next cycle.
- Widths:
  - Tallies are clog2(N_EVAL+1) bits and cannot overflow.
  - Comparison 2*tally > N_EVAL is done at width+1 bits.
- Requests arriving while busy are ignored (req_ready=0). req_data and req_addr changes after acceptance have no effect.

## Timing
- Reset values:
  - req_ready=1 on the first cycle after reset release; 0 while reset is asserted.
  - rsp_valid=0; rsp_write/rsp_clean/rsp_stable=0.
  - bram_we=0; bram_addr=0; bram_din=0.
  - Tallies, eval_cnt and both toggle registers are 0.
- we pulse:
  - we_pos toggles at the posedge entering WR_DATA/WR_CLR.
  - we_neg toggles at the following negedge.
  - bram_we = we_pos ^ we_neg, so it is high for exactly half a clock period, 2*N_EVAL pulses per challenge.
  - The BRAM samples the write on the same posedge at which it sees the address, which creates the read-write collision.
- Latency: rsp_valid rises 2*N_EVAL*(1+RD_LAT)+1 cycles after the accepting edge; 33 cycles for defaults.
- Reset mid-operation: on the next posedge the block returns to IDLE.
  - Both toggles are forced to 0, so bram_we is low within half a cycle.
  - Tallies are cleared; no rsp_valid is produced.
- N_EVAL=1: every bit is unanimous, so rsp_stable is all ones.

## Structure
- Package rwc_pkg:
  - state enum;
  - default CLEAR_PATTERN;
  - clog2 function;
  - localparam bounds for N_EVAL and RD_LAT.
- Sub-module rwc_we_pulse: dual-edge toggle pulse generator.
  - Inputs: clk, w_resetn, fire.
  - Output: we.
  - It is the only negedge logic; isolating it keeps the FSM single-edge and lets timing constraints target it.
- Vote/tally datapath is a generate loop over DW in the top module.

## Test plan
- Reset, then idle → req_ready=1, rsp_valid=0, bram_we=0, all response outputs 0.
- Deterministic BRAM model (dout = last written data), req_data=32'hA5A5_0F0F, addr=10'h3FF → after 33 cycles rsp_write=A5A5_0F0F, rsp_clean=0, rsp_stable=FFFF_FFFF; 16 we pulses, each high half a period.
- Model flipping bit 0 on 3 of 8 data evaluations, with data bit 0=1 → rsp_write[0]=1, rsp_stable[0]=0. Flipping on 4 of 8 (tie) → rsp_write[0]=0.
- rsp_ready held 0 for 10 cycles while a new req_valid is present → outputs stable, req_ready=0, no we pulses. Release rsp_ready → req_ready=1 one cycle later, and the second challenge is accepted.
- w_resetn low during RD_CLR of evaluation 5 → IDLE next cycle, bram_we low, no rsp_valid; a fresh request completes with full latency.
- Parameter sweep DW=8, AW=4, N_EVAL=1, RD_LAT=2 → latency 2*1*3+1=7 cycles, rsp_stable all ones.
